// File: rtl/bcd_counter_chain.sv
// Synchronous DIGITS-wide modulo-MODULUS counter with preset, load, enable, tc/rco and sticky overflow.
// Define UPDOWN_EN to add the `up` direction port; outputs are modelled with zero delay (T_PD is range-checked only).
module bcd_counter_chain #(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 10,
  parameter int T_PD    = 0
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  set_max,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   d,
  input  logic                  en,
`ifdef UPDOWN_EN
  input  logic                  up,
`endif
  output logic [4*DIGITS-1:0]   q,
  output logic                  tc,
  output logic                  rco,
  output logic                  ovf
);

  localparam int unsigned W         = 4 * DIGITS;
  localparam logic [3:0]  MAX_DIGIT = 4'(MODULUS - 1);

  if (DIGITS < 1 || DIGITS > 8 || MODULUS < 2 || MODULUS > 16 || T_PD < 0) begin : g_bad_param
    $error("bcd_counter_chain: parameter out of range");
  end

  logic [W-1:0] cnt_q, cnt_d;
  logic         ovf_q, ovf_d;
  logic         dir_up;
  logic         step;
  logic [3:0]   dig;
  logic         all_max, all_zero;

`ifdef UPDOWN_EN
  assign dir_up = up;
`else
  assign dir_up = 1'b1;
`endif

  // Terminal-count detection straight from the registered count
  always_comb begin : tc_detect
    all_max  = 1'b1;
    all_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      all_max  = all_max  & (cnt_q[4*i +: 4] == MAX_DIGIT);
      all_zero = all_zero & (cnt_q[4*i +: 4] == 4'd0);
    end
  end

  assign tc  = dir_up ? all_max : all_zero;
  assign rco = tc & en;

  // Next count: preset > load > count; a digit steps only when every lower digit sits at its rollover value
  always_comb begin : next_count
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    step  = 1'b1;
    dig   = 4'd0;
    if (set_max) begin
      for (int i = 0; i < DIGITS; i++) cnt_d[4*i +: 4] = MAX_DIGIT;
      ovf_d = 1'b0;
    end else if (load) begin
      cnt_d = d;
      ovf_d = 1'b0;
    end else if (en) begin
      if (tc) ovf_d = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
        dig = cnt_q[4*i +: 4];
        if (step) begin
          if (dir_up) cnt_d[4*i +: 4] = (dig >= MAX_DIGIT) ? 4'd0 : dig + 4'd1;
          else        cnt_d[4*i +: 4] = (dig == 4'd0) ? MAX_DIGIT : dig - 4'd1;
        end
        // Out-of-range digits wrap but never propagate a carry
        step = step & (dir_up ? (dig == MAX_DIGIT) : (dig == 4'd0));
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign q   = cnt_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_bcd_counter_chain.sv
// Self-checking bench for bcd_counter_chain: a 2-digit BCD instance and a 1-digit hex instance
// against a value-arithmetic reference model, directed cases followed by random stimulus.
module tb_bcd_counter_chain;

  localparam int ND = 2;
  localparam int NM = 10;
  localparam int HD = 1;
  localparam int HM = 16;

  logic       clk   = 1'b0;
  logic       clr_n = 1'b0;
  logic       set_max = 1'b0, load = 1'b0, en = 1'b0;
  logic [7:0] d = '0;
  logic       h_set_max = 1'b0, h_load = 1'b0, h_en = 1'b0;
  logic [3:0] h_d = '0;
`ifdef UPDOWN_EN
  logic       up = 1'b1;
`endif

  logic [7:0] q;
  logic       tc, rco, ovf;
  logic [3:0] h_q;
  logic       h_tc, h_rco, h_ovf;

  logic [7:0] m_q   = '0;
  logic       m_ovf = 1'b0;
  logic [3:0] mh_q   = '0;
  logic       mh_ovf = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bcd_counter_chain #(.DIGITS(ND), .MODULUS(NM), .T_PD(0)) u_dut (
    .clk(clk), .clr_n(clr_n), .set_max(set_max), .load(load), .d(d), .en(en),
`ifdef UPDOWN_EN
    .up(up),
`endif
    .q(q), .tc(tc), .rco(rco), .ovf(ovf)
  );

  bcd_counter_chain #(.DIGITS(HD), .MODULUS(HM), .T_PD(0)) u_hex (
    .clk(clk), .clr_n(clr_n), .set_max(h_set_max), .load(h_load), .d(h_d), .en(h_en),
`ifdef UPDOWN_EN
    .up(up),
`endif
    .q(h_q), .tc(h_tc), .rco(h_rco), .ovf(h_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic dir_now();
`ifdef UPDOWN_EN
    return up;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic tc_of(input logic [31:0] v, input int m, input int nd, input logic dir);
    logic am = 1'b1;
    logic az = 1'b1;
    for (int i = 0; i < nd; i++) begin
      am &= (v[4*i +: 4] == 4'(m - 1));
      az &= (v[4*i +: 4] == 4'd0);
    end
    return dir ? am : az;
  endfunction

  // In-range counts use plain modular arithmetic on the numeric value; out-of-range digits use the digit rules
  function automatic logic [31:0] next_count(input logic [31:0] v, input int m, input int nd, input logic dir);
    logic        ok = 1'b1;
    longint      val = 0;
    longint      span = 1;
    logic [31:0] r = v;
    logic        c = 1'b1;
    for (int i = 0; i < nd; i++) if (int'(v[4*i +: 4]) >= m) ok = 1'b0;
    if (ok) begin
      for (int i = nd - 1; i >= 0; i--) val = val * m + longint'(v[4*i +: 4]);
      for (int i = 0; i < nd; i++) span = span * m;
      val = dir ? (val + 1) % span : (val + span - 1) % span;
      r = '0;
      for (int i = 0; i < nd; i++) begin
        r[4*i +: 4] = 4'(val % m);
        val = val / m;
      end
    end else begin
      for (int i = 0; i < nd; i++) begin
        int dg = int'(v[4*i +: 4]);
        if (c) r[4*i +: 4] = dir ? ((dg >= m - 1) ? 4'd0 : 4'(dg + 1))
                                 : ((dg == 0) ? 4'(m - 1) : 4'(dg - 1));
        c = c && (dir ? (dg == m - 1) : (dg == 0));
      end
    end
    return r;
  endfunction

  task automatic check_all(input string tag);
    logic dir = dir_now();
    logic etc = tc_of(32'(m_q), NM, ND, dir);
    logic htc = tc_of(32'(mh_q), HM, HD, dir);
    chk({tag, ".q"},     32'(q),     32'(m_q));
    chk({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
    chk({tag, ".tc"},    32'(tc),    32'(etc));
    chk({tag, ".rco"},   32'(rco),   32'(etc & en));
    chk({tag, ".h_q"},   32'(h_q),   32'(mh_q));
    chk({tag, ".h_ovf"}, 32'(h_ovf), 32'(mh_ovf));
    chk({tag, ".h_tc"},  32'(h_tc),  32'(htc));
    chk({tag, ".h_rco"}, 32'(h_rco), 32'(htc & h_en));
  endtask

  task automatic model_clear();
    m_q = '0; m_ovf = 1'b0; mh_q = '0; mh_ovf = 1'b0;
  endtask

  // Advance the model with the inputs as driven, take one edge, then compare
  task automatic tick(input string tag);
    logic dir = dir_now();
    if (!clr_n) begin
      model_clear();
    end else begin
      if (set_max)   begin m_q = 8'h99; m_ovf = 1'b0; end
      else if (load) begin m_q = d;     m_ovf = 1'b0; end
      else if (en) begin
        if (tc_of(32'(m_q), NM, ND, dir)) m_ovf = 1'b1;
        m_q = 8'(next_count(32'(m_q), NM, ND, dir));
      end
      if (h_set_max)   begin mh_q = 4'hF; mh_ovf = 1'b0; end
      else if (h_load) begin mh_q = h_d;  mh_ovf = 1'b0; end
      else if (h_en) begin
        if (tc_of(32'(mh_q), HM, HD, dir)) mh_ovf = 1'b1;
        mh_q = 4'(next_count(32'(mh_q), HM, HD, dir));
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic async_clear(input string tag);
    #2 clr_n = 1'b0;
    model_clear();
    #1 check_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_all("reset");
    chk("reset.q_zero", 32'(q), 32'h0);
    chk("reset.tc_zero", 32'(tc), 32'h0);
    clr_n = 1'b1;

    en = 1'b1;
    repeat (99) tick("up99");
    chk("at99.q", 32'(q), 32'h99);
    chk("at99.tc", 32'(tc), 32'h1);
    chk("at99.rco", 32'(rco), 32'h1);
    chk("at99.ovf", 32'(ovf), 32'h0);
    tick("wrap");
    chk("wrap.q", 32'(q), 32'h00);
    chk("wrap.ovf", 32'(ovf), 32'h1);
    chk("wrap.tc", 32'(tc), 32'h0);

    load = 1'b1; d = 8'h47;
    tick("load47");
    chk("load47.q", 32'(q), 32'h47);
    chk("load47.ovf", 32'(ovf), 32'h0);
    load = 1'b0;
    tick("inc48");
    chk("inc48.q", 32'(q), 32'h48);
    set_max = 1'b1;
    tick("preset");
    chk("preset.q", 32'(q), 32'h99);
    chk("preset.ovf", 32'(ovf), 32'h0);
    set_max = 1'b0;

    en = 1'b0; load = 1'b1; d = 8'h53;
    tick("load53");
    d = 8'h77; en = 1'b1;
    async_clear("clr_mid");
    chk("clr_mid.q", 32'(q), 32'h00);
    tick("clr_hold");
    chk("clr_hold.q", 32'(q), 32'h00);
    #2 clr_n = 1'b1;
    load = 1'b0; en = 1'b0;

    h_en = 1'b1;
    repeat (15) tick("hex_up");
    chk("hex15.q", 32'(h_q), 32'hF);
    chk("hex15.tc", 32'(h_tc), 32'h1);
    h_en = 1'b0; h_load = 1'b1; h_d = 4'hC;
    tick("hex_load");
    h_load = 1'b0;
    repeat (3) tick("hex_hold");
    chk("hex_hold.q", 32'(h_q), 32'hC);
    chk("hex_hold.rco", 32'(h_rco), 32'h0);

`ifdef UPDOWN_EN
    load = 1'b1; d = 8'h10;
    tick("ud_load10");
    load = 1'b0; up = 1'b0;
    #1 check_all("ud_dir");
    en = 1'b1;
    tick("ud_down");
    chk("ud_down.q", 32'(q), 32'h09);
    en = 1'b0; load = 1'b1; d = 8'h00;
    tick("ud_load00");
    chk("ud_tc00", 32'(tc), 32'h1);
    load = 1'b0; en = 1'b1;
    tick("ud_under");
    chk("ud_under.q", 32'(q), 32'h99);
    chk("ud_under.ovf", 32'(ovf), 32'h1);
    chk("ud_under.tc", 32'(tc), 32'h0);
    up = 1'b1;
`endif

    en = 1'b1; load = 1'b1; d = 8'h0C;
    tick("oor_load");
    load = 1'b0;
    tick("oor_step");
    chk("oor_step.q", 32'(q), 32'h00);

    for (int k = 0; k < 3000; k++) begin
      set_max   = ($urandom_range(0, 31) == 0);
      load      = ($urandom_range(0, 7) == 0);
      en        = ($urandom_range(0, 3) != 0);
      d         = 8'($urandom);
      h_set_max = ($urandom_range(0, 31) == 0);
      h_load    = ($urandom_range(0, 7) == 0);
      h_en      = ($urandom_range(0, 3) != 0);
      h_d       = 4'($urandom);
`ifdef UPDOWN_EN
      up        = 1'($urandom);
`endif
      #1 check_all("rnd_comb");
      if ($urandom_range(0, 99) == 0) begin
        async_clear("rnd_clr");
        tick("rnd_clr_edge");
        #2 clr_n = 1'b1;
      end else begin
        tick("rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
